// File: rtl/rvga_types.sv
// Shared decode types for the rvga core: instruction formats, opcodes and
// the packet layout buffered between decode and issue.
package rvga_types;

    typedef logic [31:0] rvga_word;

    typedef enum logic [2:0] {
        e_rvga_inst_type_r = 3'd0,
        e_rvga_inst_type_i = 3'd1,
        e_rvga_inst_type_s = 3'd2,
        e_rvga_inst_type_b = 3'd3,
        e_rvga_inst_type_u = 3'd4,
        e_rvga_inst_type_j = 3'd5
    } rvga_inst_type;

    typedef enum logic [6:0] {
        OPC_LUI      = 7'b0110111,
        OPC_AUIPC    = 7'b0010111,
        OPC_JAL      = 7'b1101111,
        OPC_JALR     = 7'b1100111,
        OPC_BRANCH   = 7'b1100011,
        OPC_LOAD     = 7'b0000011,
        OPC_STORE    = 7'b0100011,
        OPC_OP_IMM   = 7'b0010011,
        OPC_OP       = 7'b0110011
    } rvga_opcode_e;

    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // The PC is parameterised per instance, so it is buffered alongside
    // this struct rather than inside it.
    typedef struct packed {
        rvga_inst_type inst_type;
        rvga_word      imm;
        logic [4:0]    rd;
        logic [4:0]    rs1;
        logic [4:0]    rs2;
        logic [2:0]    funct3;
        logic [6:0]    opcode;
        logic          illegal;
    } rvga_dec_pkt_s;

endpackage

// File: rtl/imm_construct.sv
// Builds the sign-extended immediate for a classified instruction word.
// Only inst[31:7] carries immediate bits, so the opcode is not an input.
module imm_construct
    import rvga_types::*;
(
    input  logic [31:7]   inst_i,
    input  rvga_inst_type inst_type_i,
    input  logic          shift_v_i,
    output rvga_word      imm_o
);

    // Format-directed immediate assembly; shifts keep only the shamt field.
    always_comb begin
        imm_o = '0;
        case (inst_type_i)
            e_rvga_inst_type_i: begin
                if (shift_v_i) imm_o = {27'd0, inst_i[24:20]};
                else           imm_o = {{20{inst_i[31]}}, inst_i[31:20]};
            end
            e_rvga_inst_type_s: imm_o = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            e_rvga_inst_type_b: imm_o = {{19{inst_i[31]}}, inst_i[31], inst_i[7],
                                         inst_i[30:25], inst_i[11:8], 1'b0};
            e_rvga_inst_type_u: imm_o = {inst_i[31:12], 12'd0};
            e_rvga_inst_type_j: imm_o = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                                         inst_i[20], inst_i[30:21], 1'b0};
            default:            imm_o = '0;
        endcase
    end

endmodule

// File: rtl/decode_queue.sv
// Decode front end: classifies fetched words, builds immediates and buffers
// decoded packets in a small FIFO presented to issue.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1; the sender holds its payload stable while valid=1 and ready=0.
// flush_i wins over both transfers in the same cycle.
module decode_queue
    import rvga_types::*;
#(
    parameter int DEPTH    = 2,
    parameter int PC_WIDTH = 32
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic                flush_i,
    input  logic                fetch_v_i,
    input  logic [31:0]         fetch_inst_i,
    input  logic [PC_WIDTH-1:0] fetch_pc_i,
    output logic                fetch_ready_o,
    output logic                dec_v_o,
    input  logic                dec_ready_i,
    output logic [PC_WIDTH-1:0] dec_pc_o,
    output rvga_inst_type       dec_inst_type_o,
    output rvga_word            dec_imm_o,
    output logic [4:0]          dec_rd_o,
    output logic [4:0]          dec_rs1_o,
    output logic [4:0]          dec_rs2_o,
    output logic [2:0]          dec_funct3_o,
    output logic [6:0]          dec_opcode_o,
    output logic                dec_illegal_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [CNT_W-1:0]    count_q, count_d;
    logic [PTR_W-1:0]    rptr_q, rptr_d;
    logic [PTR_W-1:0]    wptr_q, wptr_d;
    rvga_dec_pkt_s       pkt_mem_q [DEPTH];
    logic [PC_WIDTH-1:0] pc_mem_q  [DEPTH];

    rvga_inst_type in_type;
    logic          in_illegal;
    logic          in_shift_v;
    rvga_word      in_imm;
    rvga_dec_pkt_s in_pkt;
    logic          push, pop;

    // Opcode classification of the incoming word.
    always_comb begin
        in_type    = e_rvga_inst_type_r;
        in_illegal = 1'b0;
        if (fetch_inst_i[1:0] != 2'b11) begin
            in_illegal = 1'b1;
        end else begin
            case (fetch_inst_i[6:0])
                OPC_LUI, OPC_AUIPC:                 in_type = e_rvga_inst_type_u;
                OPC_JAL:                            in_type = e_rvga_inst_type_j;
                OPC_JALR, OPC_LOAD, OPC_OP_IMM,
                OPC_MISC_MEM, OPC_SYSTEM:           in_type = e_rvga_inst_type_i;
                OPC_BRANCH:                         in_type = e_rvga_inst_type_b;
                OPC_STORE:                          in_type = e_rvga_inst_type_s;
                OPC_OP:                             in_type = e_rvga_inst_type_r;
                default:                            in_illegal = 1'b1;
            endcase
        end
    end

    assign in_shift_v = (fetch_inst_i[6:0] == OPC_OP_IMM) &&
                        ((fetch_inst_i[14:12] == 3'b001) || (fetch_inst_i[14:12] == 3'b101));

    imm_construct u_imm (
        .inst_i      (fetch_inst_i[31:7]),
        .inst_type_i (in_type),
        .shift_v_i   (in_shift_v),
        .imm_o       (in_imm)
    );

    // Packet written into the queue on a push.
    always_comb begin
        in_pkt           = '0;
        in_pkt.inst_type = in_type;
        in_pkt.imm       = in_imm;
        in_pkt.rd        = fetch_inst_i[11:7];
        in_pkt.rs1       = fetch_inst_i[19:15];
        in_pkt.rs2       = fetch_inst_i[24:20];
        in_pkt.funct3    = fetch_inst_i[14:12];
        in_pkt.opcode    = fetch_inst_i[6:0];
        in_pkt.illegal   = in_illegal;
    end

    // Flags come from registered count only, so ready never depends on dec_ready_i.
    assign fetch_ready_o = (count_q != CNT_W'(DEPTH));
    assign dec_v_o       = (count_q != '0);
    assign push          = fetch_v_i & fetch_ready_o & ~flush_i;
    assign pop           = dec_v_o & dec_ready_i & ~flush_i;

    // Next-state for occupancy and pointers; flush empties the queue.
    always_comb begin
        count_d = count_q;
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        if (flush_i) begin
            count_d = '0;
            rptr_d  = '0;
            wptr_d  = '0;
        end else begin
            if (push) wptr_d = wptr_q + 1'b1;
            if (pop)  rptr_d = rptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end
    end

    // Occupancy and pointer registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q <= '0;
            rptr_q  <= '0;
            wptr_q  <= '0;
        end else begin
            count_q <= count_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
        end
    end

    // Packet storage; contents are meaningless until written, so not reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            pkt_mem_q[wptr_q] <= in_pkt;
            pc_mem_q[wptr_q]  <= fetch_pc_i;
        end
    end

    assign dec_pc_o        = pc_mem_q[rptr_q];
    assign dec_inst_type_o = pkt_mem_q[rptr_q].inst_type;
    assign dec_imm_o       = pkt_mem_q[rptr_q].imm;
    assign dec_rd_o        = pkt_mem_q[rptr_q].rd;
    assign dec_rs1_o       = pkt_mem_q[rptr_q].rs1;
    assign dec_rs2_o       = pkt_mem_q[rptr_q].rs2;
    assign dec_funct3_o    = pkt_mem_q[rptr_q].funct3;
    assign dec_opcode_o    = pkt_mem_q[rptr_q].opcode;
    assign dec_illegal_o   = pkt_mem_q[rptr_q].illegal;

endmodule
